vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_timing_gen.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing presets, colour width and shared types
package vga_pkg;

    localparam int VGA_COLOR_W = 10;

    // 640x480 @ 60 Hz: 25 MHz pixel clock from CLOCK_50 / 2, negative syncs
    localparam int VGA_640_H_ACTIVE = 640;
    localparam int VGA_640_H_FP     = 16;
    localparam int VGA_640_H_SYNC   = 96;
    localparam int VGA_640_H_BP     = 48;
    localparam int VGA_640_V_ACTIVE = 480;
    localparam int VGA_640_V_FP     = 10;
    localparam int VGA_640_V_SYNC   = 2;
    localparam int VGA_640_V_BP     = 33;
    localparam int VGA_640_CLK_DIV  = 2;
    localparam int VGA_640_SYNC_POL = 0;

    // 800x600 @ 72 Hz: 50 MHz pixel clock straight from CLOCK_50, positive syncs
    localparam int VGA_800_H_ACTIVE = 800;
    localparam int VGA_800_H_FP     = 56;
    localparam int VGA_800_H_SYNC   = 120;
    localparam int VGA_800_H_BP     = 64;
    localparam int VGA_800_V_ACTIVE = 600;
    localparam int VGA_800_V_FP     = 37;
    localparam int VGA_800_V_SYNC   = 6;
    localparam int VGA_800_V_BP     = 23;
    localparam int VGA_800_CLK_DIV  = 1;
    localparam int VGA_800_SYNC_POL = 1;

    typedef struct packed {
        logic [VGA_COLOR_W-1:0] r;
        logic [VGA_COLOR_W-1:0] g;
        logic [VGA_COLOR_W-1:0] b;
    } rgb_t;

    // Active-high timing flags carried through the pixel-latency pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
    } sync_flags_t;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - shift register with advance enable, sync clear and reset value
module vga_delay_line #(
    parameter int              WIDTH   = 1,
    parameter int              DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage [DEPTH];

        // shift one place per advance; clear wins over advance
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (clr) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else if (adv) begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing, latency-aligned sync/blank and RGB output register
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640_H_ACTIVE,
    parameter int H_FP     = VGA_640_H_FP,
    parameter int H_SYNC   = VGA_640_H_SYNC,
    parameter int H_BP     = VGA_640_H_BP,
    parameter int V_ACTIVE = VGA_640_V_ACTIVE,
    parameter int V_FP     = VGA_640_V_FP,
    parameter int V_SYNC   = VGA_640_V_SYNC,
    parameter int V_BP     = VGA_640_V_BP,
    parameter int CLK_DIV  = VGA_640_CLK_DIV,
    parameter int HS_POL   = VGA_640_SYNC_POL,
    parameter int VS_POL   = VGA_640_SYNC_POL,
    parameter int PIX_LAT  = 1,
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = VGA_COLOR_W
) (
    input  logic                   clk_50MHz,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic [3*COLOR_W-1:0]   rgb_in,
    output logic                   p_tick,
    output logic [COORD_W-1:0]     x,
    output logic [COORD_W-1:0]     y,
    output logic                   video_on,
    output logic                   line_start,
    output logic                   frame_start,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   blank_n,
    output logic [3*COLOR_W-1:0]   rgb_out
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int H_W     = $clog2(H_TOTAL);
    localparam int V_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]   H_LAST  = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_VIS   = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]   HS_BEG  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]   HS_END  = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]   V_LAST  = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_VIS   = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]   VS_BEG  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]   VS_END  = V_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HS_IDLE = (HS_POL == 0);
    localparam logic             VS_IDLE = (VS_POL == 0);

    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
        $error("vga_timing_gen: CLK_DIV and every timing field must be >= 1");
    end
    if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_lat
        $error("vga_timing_gen: PIX_LAT must be 0..7");
    end
    if (H_TOTAL >= (1 << COORD_W) || V_TOTAL >= (1 << COORD_W)) begin : g_bad_coord
        $error("vga_timing_gen: line/frame totals do not fit in COORD_W");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             active;
    logic             started;
    logic [H_W-1:0]   h_cnt;
    logic [V_W-1:0]   v_cnt;
    sync_flags_t      raw_flags;
    sync_flags_t      lat_flags;

    // active lags en by one clk so p_tick is quiet through reset and the clear cycle
    assign p_tick = active && (div_cnt == DIV_MAX);

    // pixel clock divider
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            active  <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            active  <= 1'b0;
        end else begin
            active  <= 1'b1;
            div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
        end
    end

    // x/y counters; the first tick after start only arms the counters so it can strobe frame_start at 0,0
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            started     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            started     <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (p_tick) begin
                if (!started) begin
                    started     <= 1'b1;
                    h_cnt       <= '0;
                    v_cnt       <= '0;
                    line_start  <= 1'b1;
                    frame_start <= 1'b1;
                end else if (h_cnt == H_LAST) begin
                    h_cnt      <= '0;
                    line_start <= 1'b1;
                    if (v_cnt == V_LAST) begin
                        v_cnt       <= '0;
                        frame_start <= 1'b1;
                    end else begin
                        v_cnt <= v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    assign x        = COORD_W'(h_cnt);
    assign y        = COORD_W'(v_cnt);
    assign video_on = started && (h_cnt < H_VIS) && (v_cnt < V_VIS);

    assign raw_flags.hs  = started && (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign raw_flags.vs  = started && (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign raw_flags.vis = video_on;

    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIX_LAT),
        .RST_VAL (3'b000)
    ) u_flag_delay (
        .clk     (clk_50MHz),
        .reset_n (reset_n),
        .clr     (!en),
        .adv     (p_tick),
        .d       (raw_flags),
        .q       (lat_flags)
    );

    // final stage: apply sync polarity and blank the colour in the same register as blank_n
    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            hsync   <= HS_IDLE;
            vsync   <= VS_IDLE;
            blank_n <= 1'b0;
            rgb_out <= '0;
        end else if (!en) begin
            hsync   <= HS_IDLE;
            vsync   <= VS_IDLE;
            blank_n <= 1'b0;
            rgb_out <= '0;
        end else if (p_tick) begin
            hsync   <= lat_flags.hs ^ HS_IDLE;
            vsync   <= lat_flags.vs ^ VS_IDLE;
            blank_n <= lat_flags.vis;
            rgb_out <= lat_flags.vis ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam logic [29:0] RGB_A = 30'h3FFFFFFF;
    localparam logic [29:0] RGB_B = 30'h2AAAAAAA;

    logic clk = 1'b0;
    logic reset_n;
    logic en;

    logic        a_p_tick, a_video_on, a_line_start, a_frame_start, a_hsync, a_vsync, a_blank_n;
    logic [9:0]  a_x, a_y;
    logic [29:0] a_rgb_out;
    logic        b_p_tick, b_video_on, b_line_start, b_frame_start, b_hsync, b_vsync, b_blank_n;
    logic [9:0]  b_x, b_y;
    logic [29:0] b_rgb_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk_50MHz   (clk),
        .reset_n     (reset_n),
        .en          (en),
        .rgb_in      (RGB_A),
        .p_tick      (a_p_tick),
        .x           (a_x),
        .y           (a_y),
        .video_on    (a_video_on),
        .line_start  (a_line_start),
        .frame_start (a_frame_start),
        .hsync       (a_hsync),
        .vsync       (a_vsync),
        .blank_n     (a_blank_n),
        .rgb_out     (a_rgb_out)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .CLK_DIV  (1), .HS_POL (1), .VS_POL (0), .PIX_LAT (3)
    ) dut_b (
        .clk_50MHz   (clk),
        .reset_n     (reset_n),
        .en          (en),
        .rgb_in      (RGB_B),
        .p_tick      (b_p_tick),
        .x           (b_x),
        .y           (b_y),
        .video_on    (b_video_on),
        .line_start  (b_line_start),
        .frame_start (b_frame_start),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .blank_n     (b_blank_n),
        .rgb_out     (b_rgb_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int a_ticks, a_hs_low, a_hs_x, a_vis, a_bl_x, a_vo_640, a_rgb_bad, prev_x, found;
        int b_fs_cnt, b_win, b_hs_hi, b_hs_x, b_vs_lo, b_vs_pos, b_vis, b_bl_pos, b_rgb_bad, viol;
        int fs_cyc [4];

        reset_n = 1'b0;
        en      = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_a_x", a_x, 0);
        chk("rst_a_y", a_y, 0);
        chk("rst_a_p_tick", a_p_tick, 0);
        chk("rst_a_hsync", a_hsync, 1);
        chk("rst_a_vsync", a_vsync, 1);
        chk("rst_a_blank_n", a_blank_n, 0);
        chk("rst_a_rgb", a_rgb_out, 0);
        chk("rst_a_fs", a_frame_start, 0);
        chk("rst_a_ls", a_line_start, 0);
        chk("rst_a_video_on", a_video_on, 0);
        chk("rst_b_hsync", b_hsync, 0);
        chk("rst_b_p_tick", b_p_tick, 0);

        cyc = 0;
        reset_n = 1'b1;
        step();
        chk("start_a_p_tick", a_p_tick, 1);
        chk("start_b_p_tick", b_p_tick, 1);
        chk("start_a_fs_early", a_frame_start, 0);
        step();
        chk("start_a_fs", a_frame_start, 1);
        chk("start_b_fs", b_frame_start, 1);
        chk("start_a_p_tick_off", a_p_tick, 0);
        chk("start_a_video_on", a_video_on, 1);

        a_ticks = 0; a_hs_low = 0; a_hs_x = -1; a_vis = 0; a_bl_x = -1; a_vo_640 = -1;
        a_rgb_bad = 0; prev_x = 0; found = 0;
        b_fs_cnt = 1; fs_cyc[0] = cyc; fs_cyc[1] = 0; fs_cyc[2] = 0; fs_cyc[3] = 0;
        b_win = 0; b_hs_hi = 0; b_hs_x = -1; b_vs_lo = 0; b_vs_pos = -1; b_vis = 0;
        b_bl_pos = -1; b_rgb_bad = 0;

        for (int i = 0; i < 2000; i++) begin
            if (a_p_tick) begin
                a_ticks++;
                if (!a_hsync) a_hs_low++;
                if (a_blank_n) a_vis++;
            end
            if (!a_hsync && a_hs_x < 0) a_hs_x = int'(a_x);
            if (a_blank_n && a_bl_x < 0) a_bl_x = int'(a_x);
            if (a_x == 10'd640 && a_vo_640 < 0) a_vo_640 = int'(a_video_on);
            if (a_rgb_out !== (a_blank_n ? RGB_A : 30'h0)) a_rgb_bad++;
            if (b_fs_cnt == 2) begin
                b_win++;
                if (b_hsync) b_hs_hi++;
                if (b_hsync && b_hs_x < 0) b_hs_x = int'(b_x);
                if (!b_vsync) b_vs_lo++;
                if (!b_vsync && b_vs_pos < 0) b_vs_pos = int'(b_y) * 7 + int'(b_x);
                if (b_blank_n) b_vis++;
                if (b_blank_n && b_bl_pos < 0) b_bl_pos = int'(b_y) * 7 + int'(b_x);
                if (b_rgb_out !== (b_blank_n ? RGB_B : 30'h0)) b_rgb_bad++;
            end
            prev_x = int'(a_x);
            step();
            if (b_frame_start) begin
                if (b_fs_cnt < 4) fs_cyc[b_fs_cnt] = cyc;
                b_fs_cnt++;
            end
            if (a_line_start) begin
                found = 1;
                break;
            end
        end

        chk("a_line_end_found", found, 1);
        chk("a_wrap_prev_x", prev_x, 799);
        chk("a_wrap_x", a_x, 0);
        chk("a_wrap_y", a_y, 1);
        chk("a_wrap_no_fs", a_frame_start, 0);
        chk("a_ticks_per_line", a_ticks, 800);
        chk("a_hsync_low_ticks", a_hs_low, 96);
        chk("a_hsync_first_x", a_hs_x, 658);
        chk("a_visible_ticks", a_vis, 640);
        chk("a_blank_first_x", a_bl_x, 2);
        chk("a_video_on_x640", a_vo_640, 0);
        chk("a_rgb_vs_blank", a_rgb_bad, 0);
        chk("b_frame_period", fs_cyc[2] - fs_cyc[1], 42);
        chk("b_window_len", b_win, 42);
        chk("b_hsync_high", b_hs_hi, 6);
        chk("b_hsync_x", b_hs_x, 2);
        chk("b_vsync_low", b_vs_lo, 7);
        chk("b_vsync_pos", b_vs_pos, 32);
        chk("b_visible", b_vis, 12);
        chk("b_blank_pos", b_bl_pos, 4);
        chk("b_rgb_vs_blank", b_rgb_bad, 0);

        repeat (100) step();
        chk("pre_en_drop_blank_n", a_blank_n, 1);
        en = 1'b0;
        step();
        chk("en_low_a_x", a_x, 0);
        chk("en_low_a_y", a_y, 0);
        chk("en_low_a_p_tick", a_p_tick, 0);
        chk("en_low_a_hsync", a_hsync, 1);
        chk("en_low_a_blank_n", a_blank_n, 0);
        chk("en_low_a_rgb", a_rgb_out, 0);
        chk("en_low_b_hsync", b_hsync, 0);
        viol = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (a_x != 0 || a_y != 0 || a_p_tick || a_frame_start || a_line_start ||
                b_p_tick || b_blank_n || b_x != 0) viol++;
        end
        chk("en_low_idle", viol, 0);
        en = 1'b1;
        step();
        chk("en_rise_a_p_tick", a_p_tick, 1);
        chk("en_rise_a_fs_early", a_frame_start, 0);
        step();
        chk("en_rise_a_fs", a_frame_start, 1);
        chk("en_rise_b_fs", b_frame_start, 1);
        chk("en_rise_a_x", a_x, 0);
        chk("en_rise_a_y", a_y, 0);

        found = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (a_blank_n) begin
                found = 1;
                break;
            end
        end
        chk("pre_rst_blank_found", found, 1);
        chk("pre_rst_a_rgb", a_rgb_out, RGB_A);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_a_x", a_x, 0);
        chk("async_rst_a_p_tick", a_p_tick, 0);
        chk("async_rst_a_blank_n", a_blank_n, 0);
        chk("async_rst_a_rgb", a_rgb_out, 0);
        chk("async_rst_a_hsync", a_hsync, 1);
        chk("async_rst_a_video_on", a_video_on, 0);
        chk("async_rst_b_hsync", b_hsync, 0);
        repeat (2) step();
        #2;
        reset_n = 1'b1;
        step();
        chk("rel_a_fs_glitch", a_frame_start, 0);
        chk("rel_a_ls_glitch", a_line_start, 0);
        chk("rel_b_fs_glitch", b_frame_start, 0);
        chk("rel_a_p_tick", a_p_tick, 1);
        step();
        chk("rel_a_fs", a_frame_start, 1);
        chk("rel_b_fs", b_frame_start, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
